// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate types and
// per-opcode operand-usage helpers.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                          OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM};
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {OP_OP, OP_STORE, OP_BRANCH};
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate-format classification and sign-extended immediate generation.
module imm_gen
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    output imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm_type = IMM_NONE;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm_type = IMM_I;
            OP_STORE:                 imm_type = IMM_S;
            OP_BRANCH:                imm_type = IMM_B;
            OP_LUI, OP_AUIPC:         imm_type = IMM_U;
            OP_JAL:                   imm_type = IMM_J;
            default:                  imm_type = IMM_NONE;
        endcase

        imm32 = '0;
        case (imm_type)
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register-file addressing, ID/EX pipeline register,
// load-use bubbling, flush and valid/ready back-pressure.
module id_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_val,
    input  logic [XLEN-1:0] rf_rs2_val,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd_addr,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_is_load,
    output logic            ex_illegal,
    output logic [15:0]     bubble_count
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
    logic [4:0]      rd_q, rd_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            f7b5_q, f7b5_d, load_q, load_d, illegal_q, illegal_d;
    logic [15:0]     bubble_q, bubble_d;

    imm_type_e       dec_imm_type;
    logic [XLEN-1:0] dec_imm;
    logic [6:0]      dec_op;
    logic            dec_legal, dec_rd_we, hz, adv;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst     (if_inst),
        .imm_type (dec_imm_type),
        .imm      (dec_imm)
    );

    assign rf_rs1_addr = if_inst[19:15];
    assign rf_rs2_addr = if_inst[24:20];

    always_comb begin
        dec_op    = if_inst[6:0];
        dec_legal = is_legal(dec_op);
        // R type carries no immediate but still writes rd
        dec_rd_we = dec_legal &
                    ((dec_imm_type inside {IMM_I, IMM_U, IMM_J}) | (dec_op == OP_OP));

        hz = valid_q & load_q & (rd_q != 5'd0) &
             (((rd_q == rf_rs1_addr) & uses_rs1(dec_op)) |
              ((rd_q == rf_rs2_addr) & uses_rs2(dec_op)));
        adv      = ~valid_q | ex_ready;
        if_ready = flush | (adv & ~hz);

        valid_d   = valid_q;
        pc_d      = pc_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        opcode_d  = opcode_q;
        funct3_d  = funct3_q;
        f7b5_d    = f7b5_q;
        load_d    = load_q;
        illegal_d = illegal_q;
        bubble_d  = bubble_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (adv) begin
            if (hz) begin
                valid_d = 1'b0;
                if (bubble_q != '1) bubble_d = bubble_q + 16'd1;
            end else if (if_valid) begin
                valid_d   = 1'b1;
                pc_d      = if_pc;
                rs1_d     = rf_rs1_val;
                rs2_d     = rf_rs2_val;
                imm_d     = dec_legal ? dec_imm : '0;
                rd_d      = dec_rd_we ? if_inst[11:7] : 5'd0;
                opcode_d  = dec_op;
                funct3_d  = if_inst[14:12];
                f7b5_d    = if_inst[30];
                load_d    = (dec_op == OP_LOAD);
                illegal_d = ~dec_legal;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= RESET_PC;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            f7b5_q    <= 1'b0;
            load_q    <= 1'b0;
            illegal_q <= 1'b0;
            bubble_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            f7b5_q    <= f7b5_d;
            load_q    <= load_d;
            illegal_q <= illegal_d;
            bubble_q  <= bubble_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_rs1_val   = rs1_q;
    assign ex_rs2_val   = rs2_q;
    assign ex_imm       = imm_q;
    assign ex_rd_addr   = rd_q;
    assign ex_opcode    = opcode_q;
    assign ex_funct3    = funct3_q;
    assign ex_funct7b5  = f7b5_q;
    assign ex_is_load   = load_q;
    assign ex_illegal   = illegal_q;
    assign bubble_count = bubble_q;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode pipeline stage for the RV32I core.
- Takes fetched instructions from the fetch stage and drives rs1/rs2 addresses combinationally into the register file.
- Captures operand values, decoded fields and the sign-extended immediate into an ID/EX pipeline register for the execute stage.
- Owns load-use hazard bubbling, branch/jump flush, and valid/ready back-pressure between fetch and execute.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, reset value of ex_pc.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- if_valid  in  1  fetch presents an instruction.
- if_inst  in  32  instruction word.
- if_pc  in  32  PC of if_inst.
- if_ready  out  1  stage accepts if_inst this cycle.
- rf_rs1_addr  out  5  combinational; equals if_inst[19:15].
- rf_rs2_addr  out  5  combinational; equals if_inst[24:20].
- rf_rs1_val  in  32  register-file read data; includes same-cycle write-through.
- rf_rs2_val  in  32  register-file read data.
- flush  in  1  taken branch/jump from execute; kill the ID/EX contents and the current fetch slot.
- ex_ready  in  1  execute accepts ex_* this cycle.
- ex_valid  out  1  ID/EX register holds a live instruction.
- ex_pc  out  32  registered PC.
- ex_rs1_val, ex_rs2_val  out  32 each  registered operands.
- ex_imm  out  32  sign-extended immediate.
- ex_rd_addr  out  5  destination; forced to 0 when the instruction does not write rd.
- ex_opcode  out  7  opcode.
- ex_funct3  out  3  funct3.
- ex_funct7b5  out  1  inst[30].
- ex_is_load  out  1  opcode == 7'b0000011.
- ex_illegal  out  1  opcode not in the RV32I set.
- bubble_count  out  16  saturating count of load-use bubbles inserted.

Behaviour:
- Reset values:
  - ex_valid=0, ex_pc=RESET_PC.
  - All other ex_* outputs = 0; bubble_count = 0.
  - if_ready is combinational. It is 1 during reset deassertion because ex_valid=0 and no hazard is possible.
- Reset asserted mid-operation clears the ID/EX register at once. Any in-flight instruction is lost.
- Latency: one cycle. An instruction accepted at edge N appears on ex_* after edge N.
- Load-use hazard (hz), combinational:
  - Condition: ex_valid & ex_is_load & ex_rd_addr!=0 & ((ex_rd_addr==rs1 & inst uses rs1) | (ex_rd_addr==rs2 & inst uses rs2)).
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used only by R, S and B types.
- Handshake: adv = ~ex_valid | ex_ready; if_ready = flush | (adv & ~hz).
- Clock-edge priority (after reset):
  - 1. flush: ex_valid <= 0. The incoming if_inst is consumed and discarded because if_ready=1.
  - 2. adv & hz: ex_valid <= 0, which inserts a bubble. Fetch holds its instruction because if_ready=0. bubble_count increments and saturates at 16'hFFFF.
  - 3. adv & if_valid: load all ex_* from decode; ex_valid <= 1.
  - 4. adv & ~if_valid: ex_valid <= 0.
  - 5. ~adv: hold all ex_* unchanged.
- Flush and hazard in the same cycle: flush wins and no bubble is counted.
- Immediate, by opcode:
  - I type (LOAD, OP-IMM, JALR): inst[31:20] sign-extended.
  - S type: {inst[31:25], inst[11:7]} sign-extended.
  - B type: {inst[31], inst[7], inst[30:25], inst[11:8], 0} sign-extended.
  - U type (LUI, AUIPC): {inst[31:12], 12'b0}.
  - J type: {inst[31], inst[19:12], inst[20], inst[30:21], 0} sign-extended.
  - R type and others: 0.
- ex_rd_addr is forced to 0 for S type, B type, FENCE, SYSTEM and illegal opcodes. The register file writes on every edge, so rd=0 is the no-write encoding.
- Illegal instruction handling: ex_illegal=1, ex_rd_addr=0, ex_imm=0. The instruction still passes with ex_valid=1.
- Operand capture: rf_rs*_val is sampled at the same edge as the instruction. The register file's write-through covers the writeback-to-decode forward. Execute-to-decode forwarding is not this block's job.
- Bubbles and held stages do not sample the register file.

Decomposition:
- Shared package rv32i_pkg:
  - Opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM.
  - Immediate-type enum: IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE.
- One sub-module, imm_gen: combinational, takes inst[31:0] and returns the imm type and ex_imm value.
- Hazard logic and the pipeline register stay in id_stage.

Test Plan:
- Basic decode:
  - Stimulus: reset; then if_inst=32'h00500093 (addi x1,x0,5), pc=32'h10, ex_ready=1.
  - Response: next cycle ex_valid=1, ex_pc=32'h10, ex_rd_addr=1, ex_imm=5, ex_rs1_val=0, ex_opcode=7'h13.
- Immediate and rd rules:
  - Stimulus: sw x2,-4(x1)=32'hFE20AE23.
  - Response: ex_imm=32'hFFFFFFFC, ex_rd_addr=0, rf_rs1_addr=1, rf_rs2_addr=2.
- Load-use hazard:
  - Stimulus: lw x5,0(x1) followed by add x6,x5,x7.
  - Response: if_ready=0 for one cycle; one cycle with ex_valid=0 between the two instructions; bubble_count=1; the add issues next with correct operands.
- Flush:
  - Stimulus: flush=1 while ex_valid=1 and if_valid=1.
  - Response: if_ready=1, next cycle ex_valid=0, the fetched instruction is dropped, bubble_count unchanged.
- Back-pressure:
  - Stimulus: ex_ready=0 for 3 cycles with if_valid=1.
  - Response: if_ready=0 throughout, ex_* stable, no instruction lost or duplicated after ex_ready returns.
- Async reset mid-stream:
  - Stimulus: assert reset between edges while ex_valid=1.
  - Response: ex_valid=0 and ex_pc=RESET_PC immediately, without waiting for a clock edge.
